// File: rtl/rot_pkg.sv
// Shared types for the LED rotation sequencer: FSM state encoding and direction constants.
package rot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rot_state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/rot_step.sv
// One-position rotate of a WIDTH-bit pattern; left moves bit i to i+1 with MSB wrapping to bit 0.
module rot_step
  import rot_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] din_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] dout_o
);

  always_comb begin
    if (dir_i == DIR_LEFT) dout_o = {din_i[WIDTH-2:0], din_i[WIDTH-1]};
    else                   dout_o = {din_i[0], din_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/rotate_sequencer.sv
// Timed rotate-step sequencer for the LED path. Define ROT_BOUNCE_EN to make the
// direction ping-pong after every WIDTH-1 consecutive steps instead of wrapping.
module rotate_sequencer
  import rot_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DIV_W = 26,
  parameter int CNT_W = 8,
  parameter int POS_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  output logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             step_pulse,
  output logic             done,
  output logic [POS_W-1:0] pos,
  output logic             cur_dir
);

  rot_state_e       state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d, rot_pattern;
  logic [POS_W-1:0] pos_q, pos_d, pos_step;
  logic [DIV_W-1:0] div_q, div_d, period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, steps_q, steps_d;
  logic             cur_dir_q, cur_dir_d;
  logic             step_pulse_q, step_pulse_d;
  logic             start_acc, count_hit, step_en;
`ifdef ROT_BOUNCE_EN
  logic [POS_W-1:0] bounce_q, bounce_d;
`endif

  rot_step #(.WIDTH(WIDTH)) u_rot_step (
    .din_i  (pattern_q),
    .dir_i  (cur_dir_q),
    .dout_o (rot_pattern)
  );

  // load beats stop beats start; a reached count parks the run for its DONE cycle
  assign start_acc = !load && !stop && start && (state_q == ST_IDLE);
  assign count_hit = (steps_q != '0) && (cnt_q == steps_q);
  assign step_en   = !load && !stop && !count_hit && (state_q == ST_RUN) && (div_q == period_q);

  always_comb begin
    if (cur_dir_q == DIR_LEFT) pos_step = (pos_q == POS_W'(WIDTH-1)) ? '0 : pos_q + 1'b1;
    else                       pos_step = (pos_q == '0) ? POS_W'(WIDTH-1) : pos_q - 1'b1;
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_acc) state_d = ST_RUN;
        ST_RUN: begin
          if (stop)           state_d = ST_IDLE;
          else if (count_hit) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    pattern_d    = pattern_q;
    pos_d        = pos_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    steps_d      = steps_q;
    period_d     = period_q;
    cur_dir_d    = cur_dir_q;
    step_pulse_d = step_en;
`ifdef ROT_BOUNCE_EN
    bounce_d     = bounce_q;
`endif
    if (load) begin
      pattern_d = pattern_in;
      pos_d     = '0;
      div_d     = '0;
      cnt_d     = '0;
    end else if (start_acc) begin
      cur_dir_d = dir;
      steps_d   = steps;
      period_d  = period;
      div_d     = '0;
      cnt_d     = '0;
`ifdef ROT_BOUNCE_EN
      bounce_d  = '0;
`endif
    end else if (step_en) begin
      pattern_d = rot_pattern;
      pos_d     = pos_step;
      div_d     = '0;
      cnt_d     = cnt_q + 1'b1;
`ifdef ROT_BOUNCE_EN
      if (bounce_q == POS_W'(WIDTH-2)) begin
        bounce_d  = '0;
        cur_dir_d = ~cur_dir_q;
      end else begin
        bounce_d  = bounce_q + 1'b1;
      end
`endif
    end else if (state_q == ST_RUN && !stop && !count_hit) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pattern_q    <= '0;
      pos_q        <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      steps_q      <= '0;
      period_q     <= '0;
      cur_dir_q    <= 1'b0;
      step_pulse_q <= 1'b0;
`ifdef ROT_BOUNCE_EN
      bounce_q     <= '0;
`endif
    end else begin
      pattern_q    <= pattern_d;
      pos_q        <= pos_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      steps_q      <= steps_d;
      period_q     <= period_d;
      cur_dir_q    <= cur_dir_d;
      step_pulse_q <= step_pulse_d;
`ifdef ROT_BOUNCE_EN
      bounce_q     <= bounce_d;
`endif
    end
  end

  assign pattern    = pattern_q;
  assign pos        = pos_q;
  assign step_pulse = step_pulse_q;
  assign cur_dir    = cur_dir_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Bench for rotate_sequencer: vector table for the fixed-latency runs, hand sequences for
// free-run, abort, bounce (ROT_BOUNCE_EN) and mid-run reset.
module tb_rotate_sequencer;

  localparam int WIDTH = 10;
  localparam int DIV_W = 26;
  localparam int CNT_W = 8;
  localparam int POS_W = 4;
  localparam int EW    = WIDTH + POS_W + 4;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] pin;
    logic             start;
    logic             stop;
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] period;
    logic [EW-1:0]    exp;
  } vec_t;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             load, start, stop, dir;
  logic [WIDTH-1:0] pattern_in, pattern;
  logic [CNT_W-1:0] steps;
  logic [DIV_W-1:0] period;
  logic             busy, step_pulse, done, cur_dir;
  logic [POS_W-1:0] pos;

  logic [EW-1:0] exp_q[$];
  vec_t          vecs[$];
  int            n_vec = 0;
  int            n_bad = 0;

  logic [WIDTH-1:0] m_pat;
  logic [POS_W-1:0] m_pos;
  logic             m_dir;
  int               m_bounce;

  rotate_sequencer #(.WIDTH(WIDTH), .DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .load(load), .pattern_in(pattern_in), .start(start),
    .stop(stop), .dir(dir), .steps(steps), .period(period), .pattern(pattern),
    .busy(busy), .step_pulse(step_pulse), .done(done), .pos(pos), .cur_dir(cur_dir)
  );

  always #5 CLK = ~CLK;

  function automatic logic [EW-1:0] pk(input logic [WIDTH-1:0] p, input logic [POS_W-1:0] ps,
                                       input logic b, input logic sp, input logic d, input logic cd);
    return {p, ps, b, sp, d, cd};
  endfunction

  task automatic row(input logic l, input logic [WIDTH-1:0] pin, input logic st, input logic sp,
                     input logic d, input logic [CNT_W-1:0] n, input logic [DIV_W-1:0] per,
                     input logic [EW-1:0] e);
    vec_t v;
    v.load = l; v.pin = pin; v.start = st; v.stop = sp; v.dir = d;
    v.steps = n; v.period = per; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive_in(input logic l, input logic [WIDTH-1:0] pin, input logic st,
                          input logic sp, input logic d, input logic [CNT_W-1:0] n,
                          input logic [DIV_W-1:0] per);
    load = l; pattern_in = pin; start = st; stop = sp; dir = d; steps = n; period = per;
  endtask

  task automatic compare_now(input string name);
    logic [EW-1:0] got, e;
    got = pk(pattern, pos, busy, step_pulse, done, cur_dir);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued, got=%h", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got pat=%h pos=%0d busy=%b sp=%b done=%b dir=%b, exp pat=%h pos=%0d busy=%b sp=%b done=%b dir=%b",
                 name, got[EW-1 -: WIDTH], got[POS_W+3:4], got[3], got[2], got[1], got[0],
                 e[EW-1 -: WIDTH], e[POS_W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  // Inputs are driven on the falling edge; outputs are checked on the next falling edge.
  task automatic cycle_check(input string name, input logic [EW-1:0] e);
    exp_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    compare_now(name);
  endtask

  task automatic model_step();
    if (m_dir) begin
      m_pat = (m_pat << 1) | (m_pat >> (WIDTH-1));
      m_pos = (m_pos == POS_W'(WIDTH-1)) ? '0 : m_pos + 1'b1;
    end else begin
      m_pat = (m_pat >> 1) | (m_pat << (WIDTH-1));
      m_pos = (m_pos == 0) ? POS_W'(WIDTH-1) : m_pos - 1'b1;
    end
`ifdef ROT_BOUNCE_EN
    m_bounce++;
    if (m_bounce == WIDTH-1) begin
      m_bounce = 0;
      m_dir = ~m_dir;
    end
`endif
  endtask

  initial begin
    // three back-to-back steps, then DONE where start/stop must be ignored
    row(1, 10'h001, 0, 0, 0, 0, 0, pk(10'h001, 0, 0, 0, 0, 0));
    row(0, 10'h000, 1, 0, 1, 3, 0, pk(10'h001, 0, 1, 0, 0, 1));
    row(0, 10'h000, 0, 0, 0, 0, 7, pk(10'h002, 1, 1, 1, 0, 1));
    row(0, 10'h000, 0, 0, 0, 0, 7, pk(10'h004, 2, 1, 1, 0, 1));
    row(0, 10'h000, 0, 0, 0, 0, 7, pk(10'h008, 3, 1, 1, 0, 1));
    row(0, 10'h000, 0, 0, 0, 0, 0, pk(10'h008, 3, 0, 0, 1, 1));
    row(0, 10'h000, 1, 1, 0, 0, 0, pk(10'h008, 3, 0, 0, 0, 1));
    row(0, 10'h000, 0, 0, 0, 0, 0, pk(10'h008, 3, 0, 0, 0, 1));
    // period=4, one right step wrapping pos to 9
    row(1, 10'h001, 0, 0, 0, 0, 0, pk(10'h001, 0, 0, 0, 0, 1));
    row(0, 10'h000, 1, 0, 0, 1, 4, pk(10'h001, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      row(0, 10'h000, 0, 0, 1, 0, 0, pk(10'h001, 0, 1, 0, 0, 0));
    row(0, 10'h000, 0, 0, 0, 0, 0, pk(10'h200, 9, 1, 1, 0, 0));
    row(0, 10'h000, 0, 0, 0, 0, 0, pk(10'h200, 9, 0, 0, 1, 0));
    row(0, 10'h000, 0, 0, 0, 0, 0, pk(10'h200, 9, 0, 0, 0, 0));

    // reset with load held
    RST_N = 1'b0;
    drive_in(1, 10'h155, 0, 0, 0, 0, 0);
    @(negedge CLK);
    exp_q.push_back(pk('0, 0, 0, 0, 0, 0));
    compare_now("reset_state");
    RST_N = 1'b1;
    #1;
    exp_q.push_back(pk('0, 0, 0, 0, 0, 0));
    compare_now("after_release");
    @(negedge CLK);
    cycle_check("load_after_reset", pk(10'h155, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive_in(vecs[i].load, vecs[i].pin, vecs[i].start, vecs[i].stop, vecs[i].dir,
               vecs[i].steps, vecs[i].period);
      cycle_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // free run (steps=0) for a full revolution, then stop
    drive_in(1, 10'h001, 0, 0, 0, 0, 0);
    cycle_check("fr_load", pk(10'h001, 0, 0, 0, 0, 0));
    drive_in(0, 10'h000, 1, 0, 1, 0, 0);
    cycle_check("fr_start", pk(10'h001, 0, 1, 0, 0, 1));
    m_pat = 10'h001; m_pos = '0; m_dir = 1'b1; m_bounce = 0;
    drive_in(0, 10'h000, 0, 0, 1, 0, 0);
    for (int i = 1; i <= WIDTH; i++) begin
      m_pat = (m_pat << 1) | (m_pat >> (WIDTH-1));
      m_pos = (m_pos == POS_W'(WIDTH-1)) ? '0 : m_pos + 1'b1;
      cycle_check($sformatf("fr_step%0d", i), pk(m_pat, m_pos, 1, 1, 0, 1));
    end
    drive_in(0, 10'h000, 0, 1, 0, 0, 0);
    cycle_check("fr_stop", pk(10'h001, 0, 0, 0, 0, 1));
    drive_in(0, 10'h000, 0, 0, 0, 0, 0);
    cycle_check("fr_after_stop", pk(10'h001, 0, 0, 0, 0, 1));

    // load+stop+start together mid-run, on a cycle that would otherwise step
    drive_in(1, 10'h001, 0, 0, 0, 0, 0);
    cycle_check("ab_load", pk(10'h001, 0, 0, 0, 0, 1));
    drive_in(0, 10'h000, 1, 0, 0, 0, 1);
    cycle_check("ab_start", pk(10'h001, 0, 1, 0, 0, 0));
    drive_in(0, 10'h000, 0, 0, 0, 0, 1);
    cycle_check("ab_wait", pk(10'h001, 0, 1, 0, 0, 0));
    cycle_check("ab_step", pk(10'h200, 9, 1, 1, 0, 0));
    cycle_check("ab_wait2", pk(10'h200, 9, 1, 0, 0, 0));
    drive_in(1, 10'h2AA, 1, 1, 1, 5, 0);
    cycle_check("ab_all", pk(10'h2AA, 0, 0, 0, 0, 0));
    drive_in(0, 10'h000, 0, 0, 0, 0, 0);
    cycle_check("ab_idle", pk(10'h2AA, 0, 0, 0, 0, 0));

    // 18-step run: ping-pong with ROT_BOUNCE_EN, plain wrap otherwise
    drive_in(1, 10'h001, 0, 0, 0, 0, 0);
    cycle_check("bn_load", pk(10'h001, 0, 0, 0, 0, 0));
    drive_in(0, 10'h000, 1, 0, 1, 18, 0);
    cycle_check("bn_start", pk(10'h001, 0, 1, 0, 0, 1));
    drive_in(0, 10'h000, 0, 0, 0, 0, 0);
    m_pat = 10'h001; m_pos = '0; m_dir = 1'b1; m_bounce = 0;
    for (int i = 1; i <= 18; i++) begin
      model_step();
      cycle_check($sformatf("bn_step%0d", i), pk(m_pat, m_pos, 1, 1, 0, m_dir));
    end
    cycle_check("bn_done", pk(m_pat, m_pos, 0, 0, 1, m_dir));
    cycle_check("bn_idle", pk(m_pat, m_pos, 0, 0, 0, m_dir));

    // asynchronous reset in the middle of a run
    drive_in(1, 10'h001, 0, 0, 0, 0, 0);
    cycle_check("rs_load", pk(10'h001, 0, 0, 0, 0, m_dir));
    drive_in(0, 10'h000, 1, 0, 1, 4, 0);
    cycle_check("rs_start", pk(10'h001, 0, 1, 0, 0, 1));
    drive_in(0, 10'h000, 0, 0, 0, 0, 0);
    cycle_check("rs_step1", pk(10'h002, 1, 1, 1, 0, 1));
    #2;
    RST_N = 1'b0;
    #1;
    exp_q.push_back(pk('0, 0, 0, 0, 0, 0));
    compare_now("rs_async");
    @(negedge CLK);
    exp_q.push_back(pk('0, 0, 0, 0, 0, 0));
    compare_now("rs_held");
    RST_N = 1'b1;
    cycle_check("rs_released", pk('0, 0, 0, 0, 0, 0));

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expected: got=%0d entries, exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
